// File: rtl/script_loader.sv
// Script memory loader: assembles big-endian 16-bit words from a byte stream,
// validates opcodes and writes words sequentially from address 0.
module script_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              loading,
  output logic              done,
  output logic              err_opcode,
  output logic              err_overflow
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [7:0]        hi_reg, lo_reg;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [15:0]       data_q;
  logic              err_op_q, err_ovf_q;
  logic              xfer, op_illegal, op_term, at_last;

  always_comb begin
    state_nx   = state;
    in_ready   = (state == HI) || (state == LO);
    xfer       = in_ready && in_valid;
    op_illegal = lo_reg[2] && (lo_reg[1:0] != 2'b00);
    op_term    = (lo_reg[2:0] == 3'b000);
    at_last    = (addr == '1);
    // A word caught by start or rst in its WRITE cycle is discarded with the load
    wr_en      = (state == WRITE) && !op_illegal && !rst && !start;

    case (state)
      IDLE:    state_nx = IDLE;
      HI:      if (xfer) state_nx = LO;
      LO:      if (xfer) state_nx = WRITE;
      WRITE:   state_nx = (op_illegal || op_term || at_last) ? DONE : HI;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase

    if (start) state_nx = HI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
      addr      <= '0;
      count     <= '0;
      data_q    <= '0;
      err_op_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr      <= '0;
        count     <= '0;
        err_op_q  <= 1'b0;
        err_ovf_q <= 1'b0;
      end else begin
        if (state == HI && xfer) hi_reg <= in_byte;
        if (state == LO && xfer) lo_reg <= in_byte;
        if (wr_en) begin
          data_q <= {hi_reg, lo_reg};
          count  <= count + 1'b1;
          if (!op_term && !at_last) addr <= addr + 1'b1;
          if (!op_term && at_last) err_ovf_q <= 1'b1;
        end
        if (state == WRITE && op_illegal) err_op_q <= 1'b1;
      end
    end
  end

  assign wr_addr      = addr;
  assign wr_data      = wr_en ? {hi_reg, lo_reg} : data_q;
  assign word_count   = count;
  assign loading      = (state == HI) || (state == LO) || (state == WRITE);
  assign done         = (state == DONE);
  assign err_opcode   = err_op_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_script_loader.sv
// Bench for script_loader: directed and random loads on a 256-word and a
// 4-word instance, checked against a word-list model of the load rules.
module tb_script_loader;

  typedef logic [15:0] word_q_t[$];
  typedef logic [7:0]  byte_q_t[$];
  typedef logic [23:0] wr_q_t[$];

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  in_byte_a, in_byte_b;
  logic        in_valid_a, in_valid_b;

  logic        in_ready_a, wr_en_a, loading_a, done_a, err_opcode_a, err_overflow_a;
  logic [7:0]  wr_addr_a;
  logic [15:0] wr_data_a;
  logic [8:0]  word_count_a;

  logic        in_ready_b, wr_en_b, loading_b, done_b, err_opcode_b, err_overflow_b;
  logic [1:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [2:0]  word_count_b;

  int          errors = 0;
  int          checks = 0;
  wr_q_t       got_a, got_b;
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  always #5 clk = ~clk;

  script_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .word_count(word_count_a), .loading(loading_a), .done(done_a),
    .err_opcode(err_opcode_a), .err_overflow(err_overflow_a)
  );

  script_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .word_count(word_count_b), .loading(loading_b), .done(done_b),
    .err_opcode(err_opcode_b), .err_overflow(err_overflow_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write capture, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (wr_en_a === 1'b1) begin
      got_a.push_back({wr_addr_a, wr_data_a});
      chk("ready_during_write_a", 32'(in_ready_a), 32'd0);
    end
    if (wr_en_b === 1'b1) begin
      got_b.push_back({6'd0, wr_addr_b, wr_data_b});
      chk("ready_during_write_b", 32'(in_ready_b), 32'd0);
    end
  end

  task automatic get_status(input bit sel, output logic [31:0] cnt, output logic [31:0] adr,
                            output logic dn, output logic eo, output logic ev,
                            output logic rdy, output logic ld, output logic we,
                            output logic [15:0] wd);
    if (sel) begin
      cnt = 32'(word_count_b); adr = 32'(wr_addr_b); dn = done_b; eo = err_opcode_b;
      ev = err_overflow_b; rdy = in_ready_b; ld = loading_b; we = wr_en_b; wd = wr_data_b;
    end else begin
      cnt = 32'(word_count_a); adr = 32'(wr_addr_a); dn = done_a; eo = err_opcode_a;
      ev = err_overflow_a; rdy = in_ready_a; ld = loading_a; we = wr_en_a; wd = wr_data_a;
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic [31:0] cnt, adr;
    logic dn, eo, ev, rdy, ld, we;
    logic [15:0] wd;
    get_status(sel, cnt, adr, dn, eo, ev, rdy, ld, we, wd);
    chk({tag, "_in_ready"},   32'(rdy), 32'd0);
    chk({tag, "_wr_en"},      32'(we),  32'd0);
    chk({tag, "_loading"},    32'(ld),  32'd0);
    chk({tag, "_done"},       32'(dn),  32'd0);
    chk({tag, "_err_opcode"}, 32'(eo),  32'd0);
    chk({tag, "_err_ovf"},    32'(ev),  32'd0);
    chk({tag, "_wr_addr"},    adr,      32'd0);
    chk({tag, "_wr_data"},    32'(wd),  32'd0);
    chk({tag, "_word_count"}, cnt,      32'd0);
  endtask

  // Reference: walk the word list applying the load rules directly.
  task automatic model(input int depth, input word_q_t words, output wr_q_t exp_w,
                       output int cnt, output bit eop, output bit eovf, output int used);
    int addr;
    logic [2:0] op;
    addr = 0; cnt = 0; eop = 0; eovf = 0; used = 0;
    exp_w.delete();
    for (int i = 0; i < words.size(); i++) begin
      op = words[i][2:0];
      used += 2;
      if (op >= 3'd5) begin eop = 1; break; end
      exp_w.push_back({addr[7:0], words[i]});
      cnt++;
      if (op == 3'd0) break;
      if (addr == depth - 1) begin eovf = 1; break; end
      addr++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    got_a.delete();
    got_b.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input bit sel, input word_q_t words, input bit toggle, input string tag);
    byte_q_t bytes;
    wr_q_t exp_w, got;
    int cnt, used, idx, cyc;
    bit eop, eovf, ph;
    logic v;
    logic [31:0] s_cnt, s_adr;
    logic s_dn, s_eo, s_ev, s_rdy, s_ld, s_we;
    logic [15:0] s_wd, last;
    logic [23:0] tmp;

    foreach (words[i]) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
    end
    model(sel ? 4 : 256, words, exp_w, cnt, eop, eovf, used);

    pulse_start();
    get_status(sel, s_cnt, s_adr, s_dn, s_eo, s_ev, s_rdy, s_ld, s_we, s_wd);
    chk({tag, "_ready_after_start"}, 32'(s_rdy), 32'd1);

    idx = 0; cyc = 0; ph = 1'($urandom_range(0, 1));
    while (idx < bytes.size() && cyc < 1000) begin
      v = toggle ? ph : 1'b1;
      ph = ~ph;
      get_status(sel, s_cnt, s_adr, s_dn, s_eo, s_ev, s_rdy, s_ld, s_we, s_wd);
      if (s_dn) break;
      if (sel) begin in_byte_b = bytes[idx]; in_valid_b = v; end
      else     begin in_byte_a = bytes[idx]; in_valid_a = v; end
      if (v && s_rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;

    for (int k = 0; k < 10; k++) begin
      get_status(sel, s_cnt, s_adr, s_dn, s_eo, s_ev, s_rdy, s_ld, s_we, s_wd);
      if (s_dn) break;
      @(negedge clk);
    end
    get_status(sel, s_cnt, s_adr, s_dn, s_eo, s_ev, s_rdy, s_ld, s_we, s_wd);
    got = sel ? got_b : got_a;

    chk({tag, "_done"},       32'(s_dn),  32'd1);
    chk({tag, "_word_count"}, s_cnt,      32'(cnt));
    chk({tag, "_err_opcode"}, 32'(s_eo),  32'(eop));
    chk({tag, "_err_ovf"},    32'(s_ev),  32'(eovf));
    chk({tag, "_loading"},    32'(s_ld),  32'd0);
    chk({tag, "_in_ready"},   32'(s_rdy), 32'd0);
    chk({tag, "_bytes_used"}, 32'(idx),   32'(used));
    chk({tag, "_n_writes"},   32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), 32'(got[i]), 32'(exp_w[i]));

    last = sel ? last_b : last_a;
    if (exp_w.size() > 0) begin
      tmp  = exp_w[exp_w.size() - 1];
      last = tmp[15:0];
    end
    if (sel) last_b = last; else last_a = last;
    chk({tag, "_wr_data_hold"}, 32'(s_wd), 32'(last));
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int r;
    w = 16'($urandom);
    r = $urandom_range(0, 9);
    if (r < 7)      w[2:0] = 3'($urandom_range(1, 4));
    else if (r < 8) w[2:0] = 3'd0;
    else            w[2:0] = 3'($urandom_range(5, 7));
    return w;
  endfunction

  initial begin
    word_q_t w;
    bit sel;
    int len;

    rst = 1'b1; start = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_byte_a = '0; in_byte_b = '0;
    repeat (3) @(negedge clk);
    check_idle(1'b0, "reset_a");
    check_idle(1'b1, "reset_b");
    rst = 1'b0;

    // Basic load with cycle-level timing: 0x0509 then terminator
    pulse_start();
    chk("t1_ready_after_start", 32'(in_ready_a), 32'd1);
    in_valid_a = 1'b1; in_byte_a = 8'h05;
    @(negedge clk);
    in_byte_a = 8'h09;
    @(negedge clk);
    chk("t1_w0_wr_en",   32'(wr_en_a),      32'd1);
    chk("t1_w0_addr",    32'(wr_addr_a),    32'd0);
    chk("t1_w0_data",    32'(wr_data_a),    32'h0509);
    chk("t1_w0_ready",   32'(in_ready_a),   32'd0);
    chk("t1_w0_count",   32'(word_count_a), 32'd0);
    in_byte_a = 8'h00;
    @(negedge clk);
    chk("t1_count1",     32'(word_count_a), 32'd1);
    chk("t1_hold_data",  32'(wr_data_a),    32'h0509);
    chk("t1_no_wr",      32'(wr_en_a),      32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_w1_wr_en",   32'(wr_en_a),      32'd1);
    chk("t1_w1_addr",    32'(wr_addr_a),    32'd1);
    chk("t1_w1_data",    32'(wr_data_a),    32'h0000);
    in_valid_a = 1'b0;
    @(negedge clk);
    chk("t1_done",       32'(done_a),       32'd1);
    chk("t1_count2",     32'(word_count_a), 32'd2);
    chk("t1_err_op",     32'(err_opcode_a), 32'd0);
    chk("t1_err_ovf",    32'(err_overflow_a), 32'd0);
    last_a = 16'h0000;

    w.delete(); w.push_back(16'h1202); w.push_back(16'h0303); w.push_back(16'h0000);
    run_load(1'b0, w, 1'b1, "toggle");

    w.delete(); w.push_back(16'h0706);
    run_load(1'b0, w, 1'b0, "illegal");

    w.delete(); repeat (4) w.push_back(16'h0001);
    run_load(1'b1, w, 1'b0, "overflow");

    w.delete(); repeat (3) w.push_back(16'h0001); w.push_back(16'h0000);
    run_load(1'b1, w, 1'b0, "term_last");

    // Restart after a lone high byte: the stale byte must not reach memory
    pulse_start();
    in_valid_a = 1'b1; in_byte_a = 8'h77;
    @(negedge clk);
    in_valid_a = 1'b0;
    w.delete(); w.push_back(16'h040B); w.push_back(16'h0000);
    run_load(1'b0, w, 1'b0, "restart");

    for (int n = 0; n < 24; n++) begin
      w.delete();
      sel = n[0];
      len = $urandom_range(1, sel ? 6 : 5);
      for (int k = 0; k < len; k++) w.push_back(rand_word());
      w.push_back({8'($urandom), 8'($urandom) & 8'hF8});
      run_load(sel, w, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    // rst coincident with the low-byte transfer
    pulse_start();
    in_valid_a = 1'b1; in_byte_a = 8'h05;
    @(negedge clk);
    in_byte_a = 8'h09; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid_a = 1'b0;
    check_idle(1'b0, "rst_lo_a");
    check_idle(1'b1, "rst_lo_b");
    @(negedge clk);
    chk("rst_lo_no_write", 32'(got_a.size()), 32'd0);
    chk("rst_lo_still_idle", 32'(loading_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/script_loader.md
# script_loader

Writer-side counterpart to the script analyser. It accepts a byte stream from the UART receiver, assembles big-endian 16-bit script words, and writes them sequentially into script memory starting at address 0. The analyser later reads these words back from the same memory. Opcodes are validated as words arrive, a terminator word ends the load, and load status is reported to the top level.

## Interface
Parameters:
- ADDR_W, 8, script memory address width; depth = 2^ADDR_W words

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new load at address 0, aborting any load in progress
- in_byte  in  8  received byte
- in_valid  in  1  in_byte valid this cycle
- in_ready  out  1  loader accepts in_byte this cycle
- wr_en  out  1  script memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  script memory write address
- wr_data  out  16  script word: [15:8] i_num, [7:5] i_sign, [4:3] func, [2:0] op_code
- word_count  out  ADDR_W+1  words written in current/last load, including the terminator
- loading  out  1  high while in HI, LO or WRITE
- done  out  1  level; high in DONE until the next start or rst
- err_opcode  out  1  sticky; illegal op_code received; cleared by start/rst
- err_overflow  out  1  sticky; memory filled without terminator; cleared by start/rst

## Operation
- Byte transfer occurs when in_valid && in_ready. in_ready is high only in HI and LO.
- Opcode classes:
  - Legal: 001 action, 010 jump, 011 wait, 100 game.
  - 000: terminator.
  - 101–111: illegal.
- FSM states:
  - IDLE (reset state): in_ready=0. start → HI, addr←0, word_count←0, errors←0.
  - HI: on transfer, hi_reg←in_byte → LO.
  - LO: on transfer, lo_reg←in_byte → WRITE.
  - WRITE, one cycle. Action depends on op_code = lo_reg[2:0]:
    - Legal: wr_en=1, wr_data={hi_reg,lo_reg}, wr_addr=addr, word_count+1. If addr = 2^ADDR_W−1: err_overflow←1 → DONE. Otherwise addr+1 → HI.
    - Terminator: written exactly like a legal word (wr_en=1, word_count+1) → DONE. The last address may hold a terminator without overflow.
    - Illegal: no write, err_opcode←1, word_count unchanged → DONE.
  - DONE: done=1, in_ready=0. start → HI (restart as from IDLE).
- start has priority over every other transition in every state; a partially assembled word is discarded.
- rst in any state → IDLE and all outputs at reset values; nothing is written in the reset cycle.
- addr never wraps; overflow terminates the load.

## Timing
- Reset values:
  - in_ready, wr_en, loading, done, err_opcode, err_overflow = 0
  - wr_addr = 0, wr_data = 0, word_count = 0
- in_ready is asserted the cycle after start.
- wr_en is asserted the cycle after the low-byte transfer; wr_addr and wr_data are valid in that same cycle.
- Minimum 3 cycles per word (HI, LO, WRITE) with in_valid held high; in_ready=0 during WRITE.
- Status updates in the cycle after WRITE:
  - word_count updates then.
  - done rises then, for terminator, illegal opcode, or overflow.
  - err_* flags are registered at the same edge as the DONE entry.
- wr_data holds its last written value when wr_en=0.
- in_valid asserted outside HI/LO is ignored; the byte is not consumed.

## Test plan
- Reset, then start; send bytes 0x05,0x09 (action, func 01), 0x00,0x00 → write @0=0x0509, write @1=0x0000, word_count=2, done=1, no errors.
- Stream with in_valid toggling every other cycle, words 0x1202, 0x0303, 0x0000 → writes at 0,1,2 with correct data; no byte lost or duplicated.
- Send 0x07,0x06 (op 110) → no wr_en, err_opcode=1, done=1, word_count=0.
- ADDR_W=2: send four legal words 0x0001 → writes at 0..3, err_overflow=1, done=1, word_count=4. Repeat with the 4th word 0x0000 → err_overflow=0.
- start after only a high byte, then 0x04,0x0B,0x00,0x00 → first write @0=0x040B; stale byte discarded.
- rst asserted in the same cycle as the low-byte transfer → no wr_en next cycle; all outputs at reset values; IDLE.
